conv_fmap_writer: RTL and testbench

- Output-side collector for the Conv2D stream. Accepts one convolution result per `in_valid` strobe while the window sweeps the 32-wide input image row by row.
- Discards the results whose window column falls outside the valid output width.
- Packs the valid results densely into an on-chip feature-map buffer, one 28x28 map per kernel, 6 kernels in sequence.
- Provides a 1-cycle-latency read port for the downstream pooling/readout logic.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/fmap_ram.sv | 43 ++++
 rtl/conv_fmap_writer.sv | 138 +++++++++++++
 tb/tb_conv_fmap_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the Conv2D output-side blocks.
package conv_pkg;

   localparam int IMAGE_SIZE  = 32;
   localparam int CONV_SIZE   = 28;
   localparam int KERNEL_TAPS = 25;
   localparam int NUM_KERNELS = 6;
   localparam int FMAP_WORDS  = CONV_SIZE * CONV_SIZE;
   localparam int FRAME_WORDS = NUM_KERNELS * FMAP_WORDS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } fmap_state_e;

   function automatic int frame_words(input int maps, input int size);
      return maps * size * size;
   endfunction

endpackage

// File: rtl/fmap_ram.sv
// Feature-map buffer: one write port, one registered read port, read-before-write.
// Addresses at or beyond DEPTH_USED read back as zero; storage has no reset.
module fmap_ram #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 13,
   parameter int DEPTH_USED = 4704
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_USED);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   logic              raddr_ok;

   assign raddr_ok = ({1'b0, raddr_i} < LIMIT);

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Non-blocking read of mem_q sees the pre-write value on a collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= raddr_ok ? mem_q[raddr_i] : '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_fmap_writer.sv
// Collects Conv2D results, drops out-of-range columns, packs maps densely.
// Define CONV_FMAP_RELU_EN to clamp negative results to zero at the write port.
module conv_fmap_writer
   import conv_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int IN_WIDTH = IMAGE_SIZE,
   parameter int OUT_SIZE = CONV_SIZE,
   parameter int NUM_MAPS = NUM_KERNELS,
   parameter int ADDR_W   = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              map_done,
   output logic [2:0]        map_index,
   output logic              all_done,
   output logic              overflow
);

   localparam int CW = $clog2(IN_WIDTH);
   localparam int RW = $clog2(OUT_SIZE);
   localparam int MW = 3;

   localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
   localparam logic [CW-1:0] COL_KEEP = CW'(OUT_SIZE);
   localparam logic [RW-1:0] ROW_LAST = RW'(OUT_SIZE - 1);
   localparam logic [MW-1:0] MAP_LAST = MW'(NUM_MAPS - 1);

   fmap_state_e       state_q;
   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic [MW-1:0]     map_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              map_done_q;
   logic [MW-1:0]     map_index_q;
   logic              all_done_q;
   logic              overflow_q;

   logic              take;
   logic              keep;
   logic [DATA_W-1:0] wr_data;

   assign take = (state_q == CAPTURE) && in_valid;
   assign keep = take && (col_q < COL_KEEP);

`ifdef CONV_FMAP_RELU_EN
   assign wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
   assign wr_data = in_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         map_q       <= '0;
         wr_addr_q   <= '0;
         map_done_q  <= 1'b0;
         map_index_q <= '0;
         all_done_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         map_done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q    <= CAPTURE;
                  col_q      <= '0;
                  row_q      <= '0;
                  map_q      <= '0;
                  wr_addr_q  <= '0;
                  all_done_q <= 1'b0;
                  overflow_q <= 1'b0;
               end else if (in_valid) begin
                  overflow_q <= 1'b1;
               end
            end
            CAPTURE: begin
               if (in_valid) begin
                  if (keep) begin
                     wr_addr_q <= wr_addr_q + 1'b1;
                  end
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     if (row_q == ROW_LAST) begin
                        row_q       <= '0;
                        map_done_q  <= 1'b1;
                        map_index_q <= map_q;
                        if (map_q == MAP_LAST) begin
                           map_q      <= '0;
                           state_q    <= DONE;
                           all_done_q <= 1'b1;
                        end else begin
                           map_q <= map_q + 1'b1;
                        end
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fmap_ram #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH_USED (frame_words(NUM_MAPS, OUT_SIZE))
   ) u_ram (
      .clk_i   (clk),
      .rst_ni  (rst),
      .we_i    (keep),
      .waddr_i (wr_addr_q),
      .wdata_i (wr_data),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign busy      = (state_q == CAPTURE);
   assign map_done  = map_done_q;
   assign map_index = map_index_q;
   assign all_done  = all_done_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_fmap_writer.sv
// Randomized bench for conv_fmap_writer against an index-arithmetic model.
module tb_conv_fmap_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        rd_en = 1'b0;
   logic [12:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic        busy;
   logic        map_done;
   logic [2:0]  map_index;
   logic        all_done;
   logic        overflow;

   conv_fmap_writer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .map_done  (map_done),
      .map_index (map_index),
      .all_done  (all_done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int nidx = 0;
   bit cap = 0;
   int pulses = 0;
   int spur = 0;
   logic [31:0] mem_m [4704];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] kept(input logic [31:0] d);
`ifdef CONV_FMAP_RELU_EN
      return d[31] ? 32'd0 : d;
`else
      return d;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: item n of a frame lands at map*784+row*28+col when col<28.
   task automatic feed(input logic [31:0] d);
      int col, row, map;
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      if (cap) begin
         col = nidx % 32;
         row = (nidx / 32) % 28;
         map = nidx / 896;
         if (col < 28) mem_m[map*784 + row*28 + col] = kept(d);
         if ((nidx + 1) % 896 == 0) begin
            pulses++;
            chk("map_done", {31'd0, map_done}, 32'd1);
            chk("map_index", {29'd0, map_index}, map);
            chk("all_done_edge", {31'd0, all_done}, {31'd0, map == 5});
         end else if (map_done) begin
            spur++;
         end
         nidx++;
         if (nidx == 5376) cap = 0;
      end else begin
         chk("overflow_set", {31'd0, overflow}, 32'd1);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      cap  = 1;
      nidx = 0;
   endtask

   task automatic rd(input int a, output logic [31:0] v);
      rd_en   = 1'b1;
      rd_addr = a[12:0];
      tick();
      rd_en = 1'b0;
      v = rd_data;
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_map_done"}, {31'd0, map_done}, 32'd0);
      chk({tag, "_map_index"}, {29'd0, map_index}, 32'd0);
      chk({tag, "_all_done"}, {31'd0, all_done}, 32'd0);
      chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
      chk({tag, "_rd_data"}, rd_data, 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL timeout got=%0d exp=0", 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] old;
      int a;

      #12;
      chk_zero_outs("reset");
      @(negedge clk);
      rst = 1'b1;
      tick();

      feed(32'h0000_1234);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      do_start();
      chk("start_clr_ovf", {31'd0, overflow}, 32'd0);
      chk("start_busy", {31'd0, busy}, 32'd1);

      for (int n = 0; n < 896; n++) feed(n);
      chk("map0_pulses", pulses, 32'd1);
      chk("map0_busy", {31'd0, busy}, 32'd1);
      rd(0, v);   chk("rd0", v, 32'd0);
      rd(27, v);  chk("rd27", v, 32'd27);
      rd(28, v);  chk("rd28", v, 32'd32);
      rd(783, v); chk("rd783", v, 32'd891);
      tick();
      chk("rd_hold", rd_data, 32'd891);

      for (int n = 0; n < 4480; n++) feed($urandom);
      chk("f1_pulses", pulses, 32'd6);
      chk("f1_all_done", {31'd0, all_done}, 32'd1);
      chk("f1_busy", {31'd0, busy}, 32'd0);
      rd(4703, v); chk("f1_rd4703", v, mem_m[4703]);
      for (int k = 0; k < 8; k++) begin
         a = int'($urandom_range(4703, 0));
         rd(a, v);
         chk("f1_rand", v, mem_m[a]);
      end

      old = mem_m[100];
      feed(32'hDEAD_BEEF);
      chk("done_keep_all", {31'd0, all_done}, 32'd1);
      rd(100, v); chk("done_no_write", v, old);

      do_start();
      chk("restart_ovf", {31'd0, overflow}, 32'd0);
      chk("restart_all", {31'd0, all_done}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);

      pulses = 0;
      feed(32'hFFFF_FFF6);
      for (int n = 1; n < 5376; n++) feed($urandom);
      chk("f2_pulses", pulses, 32'd6);
      chk("f2_all_done", {31'd0, all_done}, 32'd1);
`ifdef CONV_FMAP_RELU_EN
      rd(0, v); chk("relu_neg", v, 32'd0);
`else
      rd(0, v); chk("raw_neg", v, 32'hFFFF_FFF6);
`endif
      rd(4703, v); chk("f2_rd4703", v, mem_m[4703]);
      for (int k = 0; k < 12; k++) begin
         a = int'($urandom_range(4703, 0));
         rd(a, v);
         chk("f2_rand", v, mem_m[a]);
      end
      rd(4704, v); chk("oob4704", v, 32'd0);
      rd(1, v);
      rd(8191, v); chk("oob8191", v, 32'd0);

      do_start();
      for (int n = 0; n < 300; n++) feed($urandom);
      rd_en = 1'b1;
      rd_addr = 13'd3;
      tick();
      rd_en = 1'b0;
      #2;
      rst = 1'b0;
      cap = 0;
      #1;
      chk_zero_outs("async_rst");
      @(negedge clk);
      rst = 1'b1;
      tick();

      do_start();
      feed(32'h0BAD_F00D);
      for (int n = 1; n < 5; n++) feed($urandom);
      old = mem_m[5];
      rd_en = 1'b1;
      rd_addr = 13'd5;
      feed(32'h0000_5A5A);
      rd_en = 1'b0;
      chk("rw_old", rd_data, old);
      rd(5, v); chk("rw_new", v, 32'h0000_5A5A);
      rd(0, v); chk("post_rst_addr0", v, 32'h0BAD_F00D);

      chk("spurious_map_done", spur, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
